// File: rtl/cursor_overlay.sv
// -----------------------------------------------------------------------------
// cursor_overlay
//
// Purpose:
//   Cursor/video mixer sitting between the character generator and the video
//   pin. Holds the committed cursor position, accepts new positions through a
//   valid/ready handshake and only commits them during vertical blanking, so
//   the cursor never tears mid-frame. Blink phase is derived from a count of
//   vblank rising edges. Supports off / blinking block / blinking underline /
//   steady block styles. The video output is registered (one cycle latency).
//
// Parameters:
//   COLS, ROWS      text geometry; positions are clamped to COLS-1 / ROWS-1
//   COL_W, ROW_W    widths of column / row buses
//   LINE_W          width of the glyph scanline index
//   UL_LINE         scanline drawn by the underline cursor
//   BLINK_FRAMES    vblank rising edges per blink half-period (>= 1)
//   VIDEO_ON        active pixel polarity; blanking drives ~VIDEO_ON
//
// Ports:
//   pclk          in   pixel clock
//   clr           in   asynchronous reset, active-low
//   hblank        in   horizontal blanking
//   vblank        in   vertical blanking
//   col, row      in   character cell of the current pixel
//   line          in   scanline within the glyph
//   char_pixel    in   glyph pixel from the character generator (1 = lit)
//   cursor_mode   in   00 off, 01 blink block, 10 blink underline, 11 steady
//   wr_valid      in   new absolute position offered
//   wr_ready      out  high when no position update is pending
//   wr_x, wr_y    in   new absolute position
//   cursor_x/_y   out  committed cursor position
//   video         out  registered video pixel
//
// Optional feature (macro CURSOR_OVERLAY_STEP_EN):
//   Adds step_valid / step_dir (00 left, 01 right, 10 up, 11 down) for
//   relative single-cell moves, saturating at the screen edges. An absolute
//   write offered in the same cycle takes priority and the step is dropped.
// -----------------------------------------------------------------------------
module cursor_overlay #(
    parameter int   COLS         = 80,
    parameter int   ROWS         = 24,
    parameter int   COL_W        = 7,
    parameter int   ROW_W        = 5,
    parameter int   LINE_W       = 4,
    parameter int   UL_LINE      = 15,
    parameter int   BLINK_FRAMES = 30,
    parameter logic VIDEO_ON     = 1'b1
) (
    input  logic              pclk,
    input  logic              clr,
    input  logic              hblank,
    input  logic              vblank,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    input  logic [LINE_W-1:0] line,
    input  logic              char_pixel,
    input  logic [1:0]        cursor_mode,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [COL_W-1:0]  wr_x,
    input  logic [ROW_W-1:0]  wr_y,
`ifdef CURSOR_OVERLAY_STEP_EN
    input  logic              step_valid,
    input  logic [1:0]        step_dir,
`endif
    output logic [COL_W-1:0]  cursor_x,
    output logic [ROW_W-1:0]  cursor_y,
    output logic              video
);

    localparam logic [COL_W-1:0]  MAX_X    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  MAX_Y    = ROW_W'(ROWS - 1);
    localparam logic [LINE_W-1:0] UL_ROW   = LINE_W'(UL_LINE);
    localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_BLINK_BL = 2'b01,
        MODE_BLINK_UL = 2'b10,
        MODE_STEADY   = 2'b11
    } mode_e;

    // State
    logic [COL_W-1:0] r_cursor_x;
    logic [ROW_W-1:0] r_cursor_y;
    logic [COL_W-1:0] r_pend_x;
    logic [ROW_W-1:0] r_pend_y;
    logic             r_pending;
    logic             r_blink_on;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_vblank_q;
    logic             r_video;

    // Combinational
    logic             w_ready;
    logic             w_load;
    logic [COL_W-1:0] w_load_x;
    logic [ROW_W-1:0] w_load_y;
    logic             w_commit;
    logic             w_vb_rise;
    logic             w_hit;
    logic             w_cur_px;
    logic             w_blank;

    assign w_ready   = ~r_pending;
    // Commit happens on any vblank edge while pending; the acceptance edge is
    // naturally excluded because r_pending is still 0 there.
    assign w_commit  = r_pending & vblank;
    assign w_vb_rise = vblank & ~r_vblank_q;
    assign w_hit     = (col == r_cursor_x) && (row == r_cursor_y);
    assign w_blank   = hblank | vblank;

    // Decide what (if anything) loads the pending position this cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_load   = 1'b0;
        w_load_x = r_cursor_x;
        w_load_y = r_cursor_y;
        if (wr_valid && w_ready) begin
            w_load   = 1'b1;
            w_load_x = (wr_x > MAX_X) ? MAX_X : wr_x;
            w_load_y = (wr_y > MAX_Y) ? MAX_Y : wr_y;
        end
`ifdef CURSOR_OVERLAY_STEP_EN
        else if (step_valid && w_ready) begin
            w_load = 1'b1;
            case (step_dir)
                2'b00: if (r_cursor_x != '0)  w_load_x = r_cursor_x - COL_W'(1);
                2'b01: if (r_cursor_x < MAX_X) w_load_x = r_cursor_x + COL_W'(1);
                2'b10: if (r_cursor_y != '0)  w_load_y = r_cursor_y - ROW_W'(1);
                default: if (r_cursor_y < MAX_Y) w_load_y = r_cursor_y + ROW_W'(1);
            endcase
        end
`endif
    end

    // Cursor pixel for the current cell, mode sampled live.
    always_comb begin
        w_cur_px = 1'b0;
        case (mode_e'(cursor_mode))
            MODE_BLINK_BL: w_cur_px = w_hit & r_blink_on;
            MODE_BLINK_UL: w_cur_px = w_hit & r_blink_on & (line == UL_ROW);
            MODE_STEADY:   w_cur_px = w_hit;
            default:       w_cur_px = 1'b0;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge pclk or negedge clr) begin
        if (!clr) begin
            r_cursor_x  <= '0;
            r_cursor_y  <= '0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pending   <= 1'b0;
            r_blink_on  <= 1'b1;
            r_frame_cnt <= '0;
            r_vblank_q  <= 1'b0;
            r_video     <= ~VIDEO_ON;
        end else begin
            r_vblank_q <= vblank;

            // Handshake and vblank commit are mutually exclusive: a load needs
            // r_pending == 0, a commit needs r_pending == 1.
            if (w_load) begin
                r_pend_x  <= w_load_x;
                r_pend_y  <= w_load_y;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_cursor_x <= r_pend_x;
                r_cursor_y <= r_pend_y;
                r_pending  <= 1'b0;
            end

            // A commit restarts the blink phase visibly on; it overrides a
            // coincident vblank rising edge.
            if (w_commit) begin
                r_blink_on  <= 1'b1;
                r_frame_cnt <= '0;
            end else if (w_vb_rise) begin
                if (r_frame_cnt == CNT_LAST) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
            end

            if (w_blank)
                r_video <= ~VIDEO_ON;
            else
                r_video <= (char_pixel ^ w_cur_px) ? VIDEO_ON : ~VIDEO_ON;
        end
    end

    assign wr_ready = w_ready;
    assign cursor_x = r_cursor_x;
    assign cursor_y = r_cursor_y;
    assign video    = r_video;

endmodule

// File: tb/tb_cursor_overlay.sv
// -----------------------------------------------------------------------------
// tb_cursor_overlay
//
// Directed bench for cursor_overlay (COLS=80, ROWS=24, BLINK_FRAMES=2,
// VIDEO_ON=1). Each task drives one scenario and compares against
// hand-computed values. Step tests are built only when
// CURSOR_OVERLAY_STEP_EN is defined.
// -----------------------------------------------------------------------------
module tb_cursor_overlay;

    logic       pclk        = 1'b0;
    logic       clr         = 1'b0;
    logic       hblank      = 1'b0;
    logic       vblank      = 1'b0;
    logic [6:0] col         = '0;
    logic [4:0] row         = '0;
    logic [3:0] line        = '0;
    logic       char_pixel  = 1'b0;
    logic [1:0] cursor_mode = 2'b00;
    logic       wr_valid    = 1'b0;
    logic [6:0] wr_x        = '0;
    logic [4:0] wr_y        = '0;
`ifdef CURSOR_OVERLAY_STEP_EN
    logic       step_valid  = 1'b0;
    logic [1:0] step_dir    = 2'b00;
`endif
    logic       wr_ready;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic       video;

    int total = 0;
    int bad   = 0;

    cursor_overlay #(
        .BLINK_FRAMES(2)
    ) dut (
        .pclk        (pclk),
        .clr         (clr),
        .hblank      (hblank),
        .vblank      (vblank),
        .col         (col),
        .row         (row),
        .line        (line),
        .char_pixel  (char_pixel),
        .cursor_mode (cursor_mode),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
`ifdef CURSOR_OVERLAY_STEP_EN
        .step_valid  (step_valid),
        .step_dir    (step_dir),
`endif
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .video       (video)
    );

    always #5 pclk = ~pclk;

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One vblank pulse: one rising edge seen by the DUT, then back to active.
    task automatic frame();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
    endtask

    task automatic write_pos(input logic [6:0] x, input logic [4:0] y);
        wr_x     = x;
        wr_y     = y;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #12;
        total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin bad++;
            $display("FAIL rst_pos: got=%0d,%0d exp=0,0", cursor_x, cursor_y); end
        total++; if (wr_ready !== 1'b1) begin bad++;
            $display("FAIL rst_ready: got=%b exp=1", wr_ready); end
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL rst_video: got=%b exp=0", video); end
        @(negedge pclk);
        clr = 1'b1;
        // blink_on comes out of reset set: block cursor at 0,0 is visible.
        cursor_mode = 2'b01; col = 7'd0; row = 5'd0; char_pixel = 1'b0;
        tick();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL rst_blink_on: got=%b exp=1", video); end
        char_pixel = 1'b1;
        tick();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL rst_invert_lit: got=%b exp=0", video); end
        col = 7'd1; char_pixel = 1'b0;
        tick();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL rst_no_hit: got=%b exp=0", video); end
    endtask

    task automatic test_write();
        cursor_mode = 2'b00; col = 7'd0; row = 5'd0; char_pixel = 1'b0;
        wr_x = 7'd10; wr_y = 5'd5; wr_valid = 1'b1;
        tick();
        total++; if (wr_ready !== 1'b0) begin bad++;
            $display("FAIL wr_ready_low: got=%b exp=0", wr_ready); end
        // Held valid with new data must not be re-accepted while pending.
        wr_x = 7'd20; wr_y = 5'd7;
        tick(2);
        wr_valid = 1'b0;
        tick();
        total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0 || wr_ready !== 1'b0) begin bad++;
            $display("FAIL wr_no_early_commit: got=%0d,%0d rdy=%b exp=0,0 rdy=0", cursor_x, cursor_y, wr_ready); end
        vblank = 1'b1;
        tick();
        total++; if (cursor_x !== 7'd10 || cursor_y !== 5'd5) begin bad++;
            $display("FAIL wr_commit: got=%0d,%0d exp=10,5", cursor_x, cursor_y); end
        total++; if (wr_ready !== 1'b1) begin bad++;
            $display("FAIL wr_ready_back: got=%b exp=1", wr_ready); end
        vblank = 1'b0;
        tick();
    endtask

    task automatic test_clamp();
        write_pos(7'd100, 5'd30);
        vblank = 1'b1;
        tick();
        total++; if (cursor_x !== 7'd79 || cursor_y !== 5'd23) begin bad++;
            $display("FAIL clamp: got=%0d,%0d exp=79,23", cursor_x, cursor_y); end
        // Accepted during vblank: the acceptance edge must not commit.
        wr_x = 7'd5; wr_y = 5'd4; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        total++; if (cursor_x !== 7'd79 || cursor_y !== 5'd23 || wr_ready !== 1'b0) begin bad++;
            $display("FAIL accept_edge_commit: got=%0d,%0d rdy=%b exp=79,23 rdy=0", cursor_x, cursor_y, wr_ready); end
        tick();
        total++; if (cursor_x !== 7'd5 || cursor_y !== 5'd4) begin bad++;
            $display("FAIL vblank_commit: got=%0d,%0d exp=5,4", cursor_x, cursor_y); end
        vblank = 1'b0;
        tick();
        write_pos(7'd79, 5'd23);
        frame();
        total++; if (cursor_x !== 7'd79 || cursor_y !== 5'd23) begin bad++;
            $display("FAIL edge_exact: got=%0d,%0d exp=79,23", cursor_x, cursor_y); end
    endtask

    task automatic test_blink();
        logic exp_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        cursor_mode = 2'b01; col = 7'd79; row = 5'd23; char_pixel = 1'b0;
        tick();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL blink_start: got=%b exp=1", video); end
        for (int k = 0; k < 6; k++) begin
            frame();
            total++; if (video !== exp_seq[k]) begin bad++;
                $display("FAIL blink_frame%0d: got=%b exp=%b", k + 1, video, exp_seq[k]); end
        end
        // Blink phase is off now: a lit glyph pixel passes through.
        char_pixel = 1'b1;
        tick();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL blink_off_lit: got=%b exp=1", video); end
        char_pixel = 1'b0;
        write_pos(7'd79, 5'd23);
        frame();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL blink_commit_reset: got=%b exp=1", video); end
        hblank = 1'b1;
        tick();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL hblank: got=%b exp=0", video); end
        hblank = 1'b0;
        frame();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL blink_after_reset1: got=%b exp=1", video); end
        frame();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL blink_after_reset2: got=%b exp=0", video); end
    endtask

    task automatic test_modes();
        write_pos(7'd3, 5'd2);
        frame();
        col = 7'd3; row = 5'd2; char_pixel = 1'b0;
        cursor_mode = 2'b10; line = 4'd15;
        tick();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL ul_line15: got=%b exp=1", video); end
        line = 4'd14;
        tick();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL ul_line14: got=%b exp=0", video); end
        line = 4'd15; char_pixel = 1'b1;
        tick();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL ul_lit: got=%b exp=0", video); end
        char_pixel = 1'b0; col = 7'd4;
        tick();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL ul_other_cell: got=%b exp=0", video); end
        col = 7'd3; cursor_mode = 2'b11; line = 4'd5;
        tick();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL steady_on: got=%b exp=1", video); end
        frame();
        frame();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL steady_blink_off: got=%b exp=1", video); end
        cursor_mode = 2'b01;
        tick();
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL block_blink_off: got=%b exp=0", video); end
        cursor_mode = 2'b00; char_pixel = 1'b0;
        tick();
        char_pixel = 1'b1;
        #1;
        total++; if (video !== 1'b0) begin bad++;
            $display("FAIL off_latency: got=%b exp=0", video); end
        tick();
        total++; if (video !== 1'b1) begin bad++;
            $display("FAIL off_passthru: got=%b exp=1", video); end
        char_pixel = 1'b0;
    endtask

    task automatic test_reset_mid_pending();
        write_pos(7'd30, 5'd12);
        total++; if (wr_ready !== 1'b0) begin bad++;
            $display("FAIL midrst_pending: got=%b exp=0", wr_ready); end
        clr = 1'b0;
        #1;
        total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0 || wr_ready !== 1'b1) begin bad++;
            $display("FAIL midrst_clear: got=%0d,%0d rdy=%b exp=0,0 rdy=1", cursor_x, cursor_y, wr_ready); end
        #2;
        clr = 1'b1;
        vblank = 1'b1;
        tick();
        total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin bad++;
            $display("FAIL midrst_discard: got=%0d,%0d exp=0,0", cursor_x, cursor_y); end
        vblank = 1'b0;
        tick();
    endtask

`ifdef CURSOR_OVERLAY_STEP_EN
    task automatic test_step();
        step_valid = 1'b1; step_dir = 2'b00;
        tick();
        step_valid = 1'b0;
        frame();
        total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin bad++;
            $display("FAIL step_left_sat: got=%0d,%0d exp=0,0", cursor_x, cursor_y); end
        step_valid = 1'b1; step_dir = 2'b10;
        tick();
        step_valid = 1'b0;
        frame();
        total++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin bad++;
            $display("FAIL step_up_sat: got=%0d,%0d exp=0,0", cursor_x, cursor_y); end
        step_valid = 1'b1; step_dir = 2'b01;
        tick();
        step_valid = 1'b0;
        total++; if (cursor_x !== 7'd0 || wr_ready !== 1'b0) begin bad++;
            $display("FAIL step_right_wait: got=%0d rdy=%b exp=0 rdy=0", cursor_x, wr_ready); end
        frame();
        total++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin bad++;
            $display("FAIL step_right: got=%0d,%0d exp=1,0", cursor_x, cursor_y); end
        step_valid = 1'b1; step_dir = 2'b11;
        wr_x = 7'd40; wr_y = 5'd10; wr_valid = 1'b1;
        tick();
        step_valid = 1'b0; wr_valid = 1'b0;
        frame();
        total++; if (cursor_x !== 7'd40 || cursor_y !== 5'd10) begin bad++;
            $display("FAIL step_vs_write: got=%0d,%0d exp=40,10", cursor_x, cursor_y); end
        step_valid = 1'b1; step_dir = 2'b11;
        tick();
        step_valid = 1'b0;
        frame();
        total++; if (cursor_x !== 7'd40 || cursor_y !== 5'd11) begin bad++;
            $display("FAIL step_down: got=%0d,%0d exp=40,11", cursor_x, cursor_y); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_clamp();
        test_blink();
        test_modes();
        test_reset_mid_pending();
`ifdef CURSOR_OVERLAY_STEP_EN
        test_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
